// File: rtl/mio_pkg.sv
// Shared types and constants for the MIO bus responder: FSM states, address
// region codes and GPIO register offsets.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mio_state_e;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'hE;
  localparam logic [3:0] REG_CNT  = 4'hF;

  // Selected by address bit 2 inside the GPIO region.
  localparam logic GPIO_LED_OFS = 1'b0;
  localparam logic GPIO_SW_OFS  = 1'b1;

  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[31:28];
  endfunction

endpackage

// File: rtl/mio_ram.sv
// Synchronous single-port word RAM: write when en&we, registered read when en&!we.
// The read register only changes on a read access, so its output holds otherwise.
module mio_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus target: request capture, programmable wait states, one-cycle acknowledge,
// decode to RAM / GPIO / cycle counter. Define MIO_COUNTER_EN to map the counter at 0xF.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_AW      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mio_state_e  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        sel_ram_q, sel_ram_d;
  logic        ready_q, ready_d;
  logic [15:0] led_q, led_d;

  logic        commit_s;
  logic        acc_we_s;
  logic        ram_en_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [31:0] ram_rdata_s;
  logic [3:0]  region_s;
  logic        unused_addr_s;

  // With zero wait states the access commits on the capture edge, before the
  // capture registers hold the request, so IDLE uses the live bus.
  assign acc_addr_s  = (state_q == IDLE) ? Addr_in : addr_q;
  assign acc_wdata_s = (state_q == IDLE) ? Data_in : wdata_q;
  assign acc_we_s    = (state_q == IDLE) ? mem_w   : we_q;
  assign region_s    = region_of(acc_addr_s);
  assign ram_en_s    = commit_s & ~reset & (region_s == REG_RAM);
  assign unused_addr_s = ^{acc_addr_s[1:0], acc_addr_s[27:RAM_AW+2]};

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
          addr_d  = Addr_in;
          wdata_d = Data_in;
          we_d    = mem_w;
          wcnt_d  = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d  = ACK;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!CPU_MIO) begin
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q <= 4'd1) begin
          state_d  = ACK;
          wcnt_d   = 4'd0;
          commit_s = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MIO_COUNTER_EN
  logic [31:0] tick_q, tick_d;

  always_comb begin
    if (commit_s && acc_we_s && (region_s == REG_CNT)) begin
      tick_d = acc_wdata_s;
    end else begin
      tick_d = tick_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 32'd0;
    end else begin
      tick_q <= tick_d;
    end
  end
`endif

  // RAM read data comes from the RAM's own read register; other regions are
  // registered here, and sel_ram_q picks between them.
  always_comb begin
    led_d     = led_q;
    rdata_d   = rdata_q;
    sel_ram_d = sel_ram_q;
    ready_d   = (state_d == ACK);
    if (commit_s && acc_we_s) begin
      if ((region_s == REG_GPIO) && (acc_addr_s[2] == GPIO_LED_OFS)) begin
        led_d = acc_wdata_s[15:0];
      end else begin
        led_d = led_q;
      end
    end else if (commit_s) begin
      sel_ram_d = (region_s == REG_RAM);
      case (region_s)
        REG_GPIO: rdata_d = (acc_addr_s[2] == GPIO_SW_OFS) ? {16'h0000, sw_in}
                                                           : {16'h0000, led_q};
`ifdef MIO_COUNTER_EN
        REG_CNT:  rdata_d = tick_q;
`endif
        default:  rdata_d = 32'h0000_0000;
      endcase
    end else begin
      sel_ram_d = sel_ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      rdata_q   <= 32'd0;
      sel_ram_q <= 1'b0;
      ready_q   <= 1'b0;
      led_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      sel_ram_q <= sel_ram_d;
      ready_q   <= ready_d;
      led_q     <= led_d;
    end
  end

  mio_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (acc_we_s),
    .addr  (acc_addr_s[RAM_AW+1:2]),
    .wdata (acc_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign Data_out  = sel_ram_q ? ram_rdata_s : rdata_q;
  assign MIO_ready = ready_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: three instances (0, 1 and 3 wait states), a table of
// transfers checked through a scoreboard, plus abort, reset and counter sequences.
module tb_mio_bus_responder;

  logic        clk;
  logic        reset;
  logic        cpu_mio [3];
  logic        mem_w   [3];
  logic [31:0] addr    [3];
  logic [31:0] din     [3];
  logic [15:0] sw      [3];
  logic [31:0] dout    [3];
  logic        ready   [3];
  logic [15:0] led     [3];

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    int          lat;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [15:0] s;
    logic [31:0] exp_data;
    bit          chk_data;
    string       nm;
  } vec_t;

  exp_t sb [$];
  vec_t tbl [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mio_bus_responder #(
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .RAM_AW      (10)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .CPU_MIO   (cpu_mio[g]),
      .mem_w     (mem_w[g]),
      .Addr_in   (addr[g]),
      .Data_in   (din[g]),
      .Data_out  (dout[g]),
      .MIO_ready (ready[g]),
      .sw_in     (sw[g]),
      .led_out   (led[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wsel(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [15:0] s, input logic [31:0] e, input bit c, input string nm);
    vec_t v;
    v = '{d, w, a, wd, s, e, c, nm};
    tbl.push_back(v);
  endtask

  // One bus transfer; after the capture edge the bus is scrambled to show the
  // request was registered.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [15:0] s, input logic [31:0] exp_data, input bit chk_data,
                      input string nm, output logic [31:0] rd, output int rcyc);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    sb.push_back('{wsel(d) + 1, exp_data, chk_data});
    mem_w[d] = w; addr[d] = a; din[d] = wd; sw[d] = s; cpu_mio[d] = 1'b1;
    n = 0; got = 1'b0; rd = 32'd0; rcyc = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (ready[d]) begin
        got = 1'b1; rd = dout[d]; rcyc = cyc;
      end else begin
        addr[d] = ~a; din[d] = ~wd; mem_w[d] = ~w;
      end
    end
    cpu_mio[d] = 1'b0;
    e = sb.pop_front();
    chk({nm, "_latency"}, 32'(n), 32'(e.lat));
    if (e.chk_data) chk({nm, "_data"}, rd, e.data);
    @(posedge clk); #1;
    chk({nm, "_pulse_width"}, 32'(ready[d]), 32'd0);
  endtask

  logic [31:0] rd;
  int          c1, c2;
  bit          seen;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_mio[i] = 1'b0; mem_w[i] = 1'b0; addr[i] = 32'd0; din[i] = 32'd0; sw[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_data_out", dout[i], 32'd0);
      chk("reset_ready", 32'(ready[i]), 32'd0);
      chk("reset_led", 32'(led[i]), 32'd0);
    end
    @(negedge clk) reset = 1'b0;

    add(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0, 1'b0, "w1_wr_ram");
    add(1, 1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 1'b1, "w1_rd_ram");
    add(0, 1'b1, 32'hE000_0000, 32'h0000_A5A5, 16'h0000, 32'h0, 1'b0, "w0_wr_led");
    add(0, 1'b0, 32'hE000_0004, 32'h0,         16'h1234, 32'h0000_1234, 1'b1, "w0_rd_sw");
    add(0, 1'b0, 32'hE000_0000, 32'h0,         16'h0000, 32'h0000_A5A5, 1'b1, "w0_rd_led");
    add(0, 1'b1, 32'h0000_0000, 32'h1357_2468, 16'h0000, 32'h0, 1'b0, "w0_wr_ram0");
    add(0, 1'b0, 32'h5000_0000, 32'h0,         16'h0000, 32'h0, 1'b1, "w0_rd_unmapped");
    add(0, 1'b1, 32'h5000_0000, 32'hFFFF_FFFF, 16'h0000, 32'h0, 1'b0, "w0_wr_unmapped");
    add(0, 1'b0, 32'hE000_0000, 32'h0,         16'h0000, 32'h0000_A5A5, 1'b1, "w0_led_kept");
    add(0, 1'b0, 32'h0000_0000, 32'h0,         16'h0000, 32'h1357_2468, 1'b1, "w0_ram0_kept");
    add(1, 1'b0, 32'h0000_1010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 1'b1, "w1_rd_alias");
    add(1, 1'b1, 32'hE000_0004, 32'hFFFF_5555, 16'h0000, 32'h0, 1'b0, "w1_wr_sw");
    add(1, 1'b0, 32'hE000_0004, 32'h0,         16'hBEEF, 32'h0000_BEEF, 1'b1, "w1_rd_sw");
    add(1, 1'b0, 32'hE000_0000, 32'h0,         16'h0000, 32'h0, 1'b1, "w1_led_zero");
    add(2, 1'b1, 32'h0000_0030, 32'h0102_0304, 16'h0000, 32'h0, 1'b0, "w3_wr_ram");
    add(2, 1'b0, 32'h0000_0030, 32'h0,         16'h0000, 32'h0102_0304, 1'b1, "w3_rd_ram");
`ifndef MIO_COUNTER_EN
    add(0, 1'b1, 32'hF000_0000, 32'h1234_5678, 16'h0000, 32'h0, 1'b0, "w0_wr_cnt_unmapped");
    add(0, 1'b0, 32'hF000_0000, 32'h0,         16'h0000, 32'h0, 1'b1, "w0_rd_cnt_unmapped");
`endif

    foreach (tbl[i]) begin
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, tbl[i].exp_data,
           tbl[i].chk_data, tbl[i].nm, rd, c1);
    end
    chk("led_w0_final", 32'(led[0]), 32'h0000_A5A5);
    chk("led_w1_final", 32'(led[1]), 32'h0000_0000);

    // Abort: drop the request in the second wait cycle of a 3-wait-state write.
    @(negedge clk);
    addr[2] = 32'h0000_0030; din[2] = 32'hCAFE_F00D; mem_w[2] = 1'b1; cpu_mio[2] = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1; seen |= ready[2];
    @(posedge clk); #1; seen |= ready[2];
    cpu_mio[2] = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= ready[2]; end
    chk("abort_no_ack", 32'(seen), 32'd0);
    xfer(2, 1'b0, 32'h0000_0030, 32'h0, 16'h0, 32'h0102_0304, 1'b1, "abort_ram_kept", rd, c1);

    // Reset during the wait states of an LED write.
    @(negedge clk);
    addr[2] = 32'hE000_0000; din[2] = 32'h0000_00FF; mem_w[2] = 1'b1; cpu_mio[2] = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1; seen |= ready[2];
    @(posedge clk); #1; seen |= ready[2];
    reset = 1'b1;
    @(posedge clk); #1; seen |= ready[2];
    reset = 1'b0; cpu_mio[2] = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= ready[2]; end
    chk("rst_no_ack", 32'(seen), 32'd0);
    chk("rst_led_w3", 32'(led[2]), 32'd0);
    chk("rst_led_w0", 32'(led[0]), 32'd0);
    chk("rst_data_out", dout[2], 32'd0);
    xfer(2, 1'b0, 32'hE000_0000, 32'h0, 16'h0, 32'h0, 1'b1, "rst_idle_led", rd, c1);
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, 16'h0, 32'hDEAD_BEEF, 1'b1, "rst_ram_kept", rd, c1);

`ifdef MIO_COUNTER_EN
    // Counter loads at the write commit edge, then counts every edge until the read commit.
    xfer(1, 1'b1, 32'hF000_0000, 32'd100, 16'h0, 32'h0, 1'b0, "cnt_wr", rd, c1);
    repeat (10) @(posedge clk);
    xfer(1, 1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'h0, 1'b0, "cnt_rd", rd, c2);
    chk("cnt_value", rd, 32'd100 + 32'(c2 - c1 - 1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
